miriscv_lsu: RTL and testbench
==============================

// Module: miriscv_lsu
// PURPOSE
//  Load/store controller between the decode/execute datapath and the data-memory port.
//  Sequences one memory transaction per core request using the mem_req/mem_we/mem_size decode outputs.
//  Stalls the core until the transaction completes.
//  Byte-lane logic: generates byte enables and replicated write data; sign/zero-extends load data.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in REQ or RESP without progress before abort; 0 = no timeout
// PORTS
//  clk_i            in   1   clock
//  rst_i            in   1   synchronous, active-high reset
//  lsu_req_i        in   1   core requests a memory access (decode mem_req)
//  lsu_we_i         in   1   1 = store, 0 = load
//  lsu_size_i       in   3   funct3: LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5
//  lsu_addr_i       in   32  byte address from ALU
//  lsu_data_i       in   32  store data (rs2)
//  lsu_data_o       out  32  extended load result, registered
//  lsu_stall_req_o  out  1   hold pipeline
//  lsu_err_o        out  1   misaligned address, illegal size, or timeout
//  data_req_o       out  1   memory request
//  data_we_o        out  1   memory write
//  data_be_o        out  4   byte enables
//  data_addr_o      out  32  {addr_q[31:2],2'b00}
//  data_wdata_o     out  32  replicated store data
//  data_gnt_i       in   1   memory accepted request
//  data_rvalid_i    in   1   response valid; read data present for loads
//  data_rdata_i     in   32  read word
// BEHAVIOUR
//  Reset: state=IDLE, lsu_data_o=0, data_req_o=0, data_we_o=0, data_be_o=0, addr/wdata regs=0, timeout cnt=0.
//  Illegal size (3,6,7) or misalignment (H/HU addr[0]=1; W addr[1:0]!=0):
//   - combinational lsu_err_o=1 while lsu_req_i high in IDLE; no access; stall=0; state stays IDLE.
//  FSM IDLE -> REQ -> RESP -> DONE -> IDLE:
//   IDLE: on legal lsu_req_i, register we/size/addr/wdata/be and go to REQ.
//   REQ:  data_req_o=1 with all data_* stable; on data_gnt_i go to RESP.
//   RESP: data_req_o=0; on data_rvalid_i capture extended load data into lsu_data_o, go to DONE.
//         Stores do not update lsu_data_o. data_rvalid_i outside RESP is ignored.
//   DONE: single cycle; unconditionally returns to IDLE.
//  Stall and latency:
//   - lsu_stall_req_o = lsu_req_i & legal & (state != DONE).
//   - Minimum latency is 3 cycles of stall: gnt in first REQ cycle, rvalid in first RESP cycle.
//  Byte enables (a = addr_q[1:0]):
//   - B/BU: 4'b0001<<a; H/HU: 4'b0011<<{a[1],1'b0}; W: 4'b1111.
//  Write data: B = {4{d[7:0]}}, H = {2{d[15:0]}}, W = d.
//  Load extraction: byte = rdata[8a+:8], half = rdata[16a[1]+:16].
//   - B/H sign-extend; BU/HU zero-extend; W as is.
//  lsu_req_i dropped mid-transaction: bus transaction still completes to DONE; result discarded.
//  Timeout: counter clears on each state change. If it reaches TIMEOUT_CYCLES in REQ or RESP:
//   - go to DONE; lsu_err_o=1 for the DONE cycle; lsu_data_o=0.
//  Reset mid-transaction: synchronous return to IDLE at the edge; data_req_o=0 next cycle; late rvalid ignored.
// TESTING
//  - LW addr=0x100, gnt immediate, rvalid next, rdata=0xDEADBEEF -> be=1111, stall 3 cycles, lsu_data_o=0xDEADBEEF.
//  - LB addr=0x103, rdata=0x80XXXXXX -> be=1000, lsu_data_o=0xFFFFFF80; LBU same -> 0x00000080.
//  - SH addr=0x102, data=0x1234ABCD, gnt after 4 cycles -> be=1100, wdata=0xABCDABCD held stable, stall 7 cycles.
//  - LW addr=0x101 and size=3 -> lsu_err_o=1, data_req_o never high, stall=0.
//  - TIMEOUT_CYCLES=8, gnt never -> DONE after 8 REQ cycles, lsu_err_o pulse, lsu_data_o=0.
//  - rst_i in RESP, then rvalid -> state IDLE, lsu_data_o stays 0, no stall.

Source files
------------

// File: rtl/miriscv_lsu.sv
// Load/store unit: runs one data-memory transaction per core request and
// stalls the core until it completes.
//   clk_i, rst_i         clock, synchronous active-high reset
//   lsu_req_i/we_i/size_i/addr_i/data_i   core request (decode/execute)
//   lsu_data_o           extended load result (registered)
//   lsu_stall_req_o      hold pipeline (combinational)
//   lsu_err_o            misaligned/illegal size in IDLE, or timeout in DONE
//   data_req_o/we_o/be_o/addr_o/wdata_o   memory request side (registered)
//   data_gnt_i/rvalid_i/rdata_i           memory handshake and read data
module miriscv_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         size_q;
    logic [31:0]        addr_q;
    logic               abort_q;

    logic               legal;
    logic               timeout_hit;
    logic               timeout_abort;
    logic [3:0]         be_d;
    logic [31:0]        wdata_d;
    logic [31:0]        byte_sh;
    logic [31:0]        half_sh;
    logic [31:0]        load_ext;

    // Request legality: supported size and natural alignment
    always_comb begin
        legal = 1'b0;
        case (lsu_size_i)
            LDST_B, LDST_BU: legal = 1'b1;
            LDST_H, LDST_HU: legal = ~lsu_addr_i[0];
            LDST_W:          legal = (lsu_addr_i[1:0] == 2'b00);
            default:         legal = 1'b0;
        endcase
    end

    // Byte enables and lane-replicated store data for the incoming request
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = lsu_data_i;
        case (lsu_size_i[1:0])
            2'd0: begin
                be_d    = 4'b0001 << lsu_addr_i[1:0];
                wdata_d = {4{lsu_data_i[7:0]}};
            end
            2'd1: begin
                be_d    = 4'b0011 << {lsu_addr_i[1], 1'b0};
                wdata_d = {2{lsu_data_i[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = lsu_data_i;
            end
        endcase
    end

    // Lane extraction and sign/zero extension of the read word
    assign byte_sh = data_rdata_i >> {addr_q[1:0], 3'b000};
    assign half_sh = data_rdata_i >> {addr_q[1], 4'b0000};

    always_comb begin
        load_ext = data_rdata_i;
        case (size_q)
            LDST_B:  load_ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
            LDST_BU: load_ext = {24'd0, byte_sh[7:0]};
            LDST_H:  load_ext = {{16{half_sh[15]}}, half_sh[15:0]};
            LDST_HU: load_ext = {16'd0, half_sh[15:0]};
            default: load_ext = data_rdata_i;
        endcase
    end

    // Abort only when the limit is hit in a cycle that made no progress
    assign timeout_hit   = TIMEOUT_EN && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_abort = timeout_hit &&
                           (((state_q == REQ)  && !data_gnt_i) ||
                            ((state_q == RESP) && !data_rvalid_i));

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (lsu_req_i && legal) state_d = REQ;
            REQ:  if (data_gnt_i || timeout_abort) state_d = (data_gnt_i ? RESP : DONE);
            RESP: if (data_rvalid_i || timeout_abort) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Core-facing handshake outputs
    always_comb begin
        lsu_stall_req_o = 1'b0;
        lsu_err_o       = 1'b0;
        lsu_stall_req_o = lsu_req_i && legal && (state_q != DONE);
        lsu_err_o       = ((state_q == IDLE) && lsu_req_i && !legal) ||
                          ((state_q == DONE) && abort_q);
    end

    assign data_addr_o = {addr_q[31:2], 2'b00};

    // Transaction registers, progress counter and load result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_req_o   <= 1'b0;
            data_we_o    <= 1'b0;
            data_be_o    <= 4'b0000;
            data_wdata_o <= 32'd0;
            size_q       <= 3'd0;
            addr_q       <= 32'd0;
            cnt_q        <= '0;
            abort_q      <= 1'b0;
            lsu_data_o   <= 32'd0;
        end else begin
            data_req_o <= (state_d == REQ);
            abort_q    <= timeout_abort;

            if ((state_q == IDLE) && (state_d == REQ)) begin
                data_we_o    <= lsu_we_i;
                data_be_o    <= be_d;
                data_wdata_o <= wdata_d;
                size_q       <= lsu_size_i;
                addr_q       <= lsu_addr_i;
            end

            if ((state_d != state_q) || !((state_q == REQ) || (state_q == RESP)))
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + CNT_W'(1);

            if (timeout_abort)
                lsu_data_o <= 32'd0;
            else if ((state_q == RESP) && data_rvalid_i && !data_we_o)
                lsu_data_o <= load_ext;
        end
    end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed bench for miriscv_lsu (TIMEOUT_CYCLES = 8).
module tb_miriscv_lsu;

    logic        clk_i;
    logic        rst_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_req_o;
    logic        lsu_err_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    int passed = 0;
    int total  = 0;
    int stall_cnt = 0;

    miriscv_lsu #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .lsu_req_i       (lsu_req_i),
        .lsu_we_i        (lsu_we_i),
        .lsu_size_i      (lsu_size_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_data_i      (lsu_data_i),
        .lsu_data_o      (lsu_data_o),
        .lsu_stall_req_o (lsu_stall_req_o),
        .lsu_err_o       (lsu_err_o),
        .data_req_o      (data_req_o),
        .data_we_o       (data_we_o),
        .data_be_o       (data_be_o),
        .data_addr_o     (data_addr_o),
        .data_wdata_o    (data_wdata_o),
        .data_gnt_i      (data_gnt_i),
        .data_rvalid_i   (data_rvalid_i),
        .data_rdata_i    (data_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Stall cycles are sampled mid-cycle, after inputs settle
    always @(negedge clk_i) if (lsu_stall_req_o) stall_cnt <= stall_cnt + 1;

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One legal transaction; gnt after gnt_wait REQ cycles, rvalid in first RESP cycle
    task automatic xact(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdat, input int gnt_wait,
                        input logic [31:0] rdata, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_data,
                        input int exp_stall);
        int base;
        base = stall_cnt;
        lsu_req_i  = 1'b1;
        lsu_we_i   = we;
        lsu_size_i = size;
        lsu_addr_i = addr;
        lsu_data_i = wdat;
        #1;
        chk({tag, ".idle_stall"}, 32'(lsu_stall_req_o), 32'd1);
        chk({tag, ".idle_err"}, 32'(lsu_err_o), 32'd0);
        tick();
        for (int i = 0; i < gnt_wait; i++) begin
            chk({tag, ".wait_req"}, 32'(data_req_o), 32'd1);
            chk({tag, ".wait_wdata"}, data_wdata_o, exp_wd);
            tick();
        end
        chk({tag, ".req"}, 32'(data_req_o), 32'd1);
        chk({tag, ".we"}, 32'(data_we_o), 32'(we));
        chk({tag, ".be"}, 32'(data_be_o), 32'(exp_be));
        chk({tag, ".addr"}, data_addr_o, {addr[31:2], 2'b00});
        chk({tag, ".wdata"}, data_wdata_o, exp_wd);
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0;
        chk({tag, ".resp_req"}, 32'(data_req_o), 32'd0);
        data_rvalid_i = 1'b1;
        data_rdata_i  = rdata;
        tick();
        data_rvalid_i = 1'b0;
        chk({tag, ".data"}, lsu_data_o, exp_data);
        chk({tag, ".done_stall"}, 32'(lsu_stall_req_o), 32'd0);
        chk({tag, ".done_err"}, 32'(lsu_err_o), 32'd0);
        lsu_req_i = 1'b0;
        tick();
        chk({tag, ".stall_cycles"}, 32'(stall_cnt - base), 32'(exp_stall));
    endtask

    initial begin
        rst_i = 1'b1;
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 3'd0;
        lsu_addr_i = 32'd0; lsu_data_i = 32'd0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'd0;
        tick();
        tick();
        chk("rst.data", lsu_data_o, 32'd0);
        chk("rst.req", 32'(data_req_o), 32'd0);
        chk("rst.we", 32'(data_we_o), 32'd0);
        chk("rst.be", 32'(data_be_o), 32'd0);
        chk("rst.addr", data_addr_o, 32'd0);
        chk("rst.stall", 32'(lsu_stall_req_o), 32'd0);
        rst_i = 1'b0;
        tick();

        xact("lw",  1'b0, 3'd2, 32'h100, 32'h0, 0, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF, 3);
        xact("lb",  1'b0, 3'd0, 32'h103, 32'h0, 0, 32'h80123456, 4'b1000, 32'h0, 32'hFFFFFF80, 3);
        xact("lbu", 1'b0, 3'd4, 32'h103, 32'h0, 0, 32'h80123456, 4'b1000, 32'h0, 32'h00000080, 3);
        xact("lh",  1'b0, 3'd1, 32'h100, 32'h0, 0, 32'h12348765, 4'b0011, 32'h0, 32'hFFFF8765, 3);
        xact("lhu", 1'b0, 3'd5, 32'h102, 32'h0, 0, 32'hF00D1234, 4'b1100, 32'h0, 32'h0000F00D, 3);
        xact("sh",  1'b1, 3'd1, 32'h102, 32'h1234ABCD, 4, 32'h0, 4'b1100, 32'hABCDABCD, 32'h0000F00D, 7);
        xact("sb",  1'b1, 3'd0, 32'h101, 32'h000000A5, 1, 32'h0, 4'b0010, 32'hA5A5A5A5, 32'h0000F00D, 4);

        // Misaligned word and illegal size: flagged, never issued
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h101;
        #1;
        chk("misal.err", 32'(lsu_err_o), 32'd1);
        chk("misal.stall", 32'(lsu_stall_req_o), 32'd0);
        tick();
        chk("misal.req", 32'(data_req_o), 32'd0);
        lsu_size_i = 3'd3; lsu_addr_i = 32'h100;
        #1;
        chk("size3.err", 32'(lsu_err_o), 32'd1);
        chk("size3.stall", 32'(lsu_stall_req_o), 32'd0);
        tick();
        chk("size3.req", 32'(data_req_o), 32'd0);
        lsu_req_i = 1'b0;
        #1;
        chk("idle.err", 32'(lsu_err_o), 32'd0);
        tick();

        // Timeout: grant never arrives, abort after 8 REQ cycles
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h200;
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("to.req8", 32'(data_req_o), 32'd1);
        chk("to.stall8", 32'(lsu_stall_req_o), 32'd1);
        tick();
        chk("to.done_req", 32'(data_req_o), 32'd0);
        chk("to.err", 32'(lsu_err_o), 32'd1);
        chk("to.stall", 32'(lsu_stall_req_o), 32'd0);
        chk("to.data", lsu_data_o, 32'd0);
        lsu_req_i = 1'b0;
        tick();
        chk("to.err_clr", 32'(lsu_err_o), 32'd0);

        // Reset in RESP, late rvalid ignored
        lsu_req_i = 1'b1; lsu_size_i = 3'd2; lsu_addr_i = 32'h300;
        tick();
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0;
        chk("rr.resp_req", 32'(data_req_o), 32'd0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        lsu_req_i = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h55AA55AA;
        #1;
        chk("rr.stall", 32'(lsu_stall_req_o), 32'd0);
        chk("rr.req", 32'(data_req_o), 32'd0);
        tick();
        data_rvalid_i = 1'b0;
        chk("rr.data", lsu_data_o, 32'd0);
        chk("rr.req2", 32'(data_req_o), 32'd0);
        tick();
        chk("rr.data2", lsu_data_o, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
